divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider_pkg.sv | 34 +++
 rtl/divu_core.sv | 63 ++++++
 rtl/divider.sv | 153 +++++++++++++++
 tb/tb_divider.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared RV32 M-extension definitions used by the multiplier and divider.
// Contents:
//   XLEN / DIV_WIDTH : default datapath width for the muldiv units
//   mul_op_t         : multiplier op encoding (funct3[1:0] of MUL*)
//   muldiv_op_t      : divider op encoding (funct3[1:0] of DIV*/REM*)
//   op_is_signed / op_is_rem : decode helpers for muldiv_op_t
package divider_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_WIDTH = XLEN;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } muldiv_op_t;

    function automatic logic op_is_signed(muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(muldiv_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/divu_core.sv
// Unsigned restoring shift-subtract divider datapath.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : load fresh operands (partial remainder cleared)
//   i_step       : perform one shift-subtract step this cycle
//   i_dividend   : unsigned dividend magnitude
//   i_divisor    : unsigned divisor magnitude
//   o_quot_next  : quotient/dividend shift register after the current step
//   o_rem_next   : partial remainder after the current step
// The "next" values are exposed so the caller can sign-fix the final step
// in the same cycle it is computed.
module divu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quot_next,
    output logic [WIDTH-1:0] o_rem_next
);

    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;

    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    // The shifted remainder needs one extra bit; when it fits, the true
    // difference is below the divisor, so the low WIDTH bits are exact.
    always_comb begin
        w_rem_shift = {r_rem, r_quot[WIDTH-1]};
        w_diff      = w_rem_shift[WIDTH-1:0] - r_divisor;
        w_fits      = (w_rem_shift >= {1'b0, r_divisor});
        if (w_fits) begin
            o_rem_next  = w_diff;
            o_quot_next = {r_quot[WIDTH-2:0], 1'b1};
        end else begin
            o_rem_next  = w_rem_shift[WIDTH-1:0];
            o_quot_next = {r_quot[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (i_load) begin
            r_quot    <= i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
        end else if (i_step) begin
            r_quot    <= o_quot_next;
            r_rem     <= o_rem_next;
        end
    end

endmodule

// File: rtl/divider.sv
// Multi-cycle RV32M divider (DIV, DIVU, REM, REMU).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a division (only honoured while idle)
//   op         : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a, b       : dividend, divisor
//   busy       : high while an operation is in flight (CALC or DONE)
//   done       : one-cycle pulse with a valid result
//   result     : quotient or remainder, held until the next result
// Divide-by-zero and signed overflow bypass the iterative core entirely.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_count;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_is_rem;
    logic [WIDTH-1:0] r_result;

    muldiv_op_t       w_op;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_zero;
    logic             w_overflow;
    logic             w_special;
    logic [WIDTH-1:0] w_special_result;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_core_quot;
    logic [WIDTH-1:0] w_core_rem;
    logic [WIDTH-1:0] w_final;

    // Operand decode on the raw inputs; only meaningful on the accepting edge.
    always_comb begin
        w_op       = muldiv_op_t'(op);
        w_signed   = op_is_signed(w_op);
        w_a_neg    = w_signed & a[WIDTH-1];
        w_b_neg    = w_signed & b[WIDTH-1];
        w_a_mag    = w_a_neg ? -a : a;
        w_b_mag    = w_b_neg ? -b : b;
        w_div_zero = (b == '0);
        w_overflow = w_signed && (a == MOST_NEG) && (b == '1);
        w_special  = w_div_zero | w_overflow;
        if (w_div_zero) begin
            w_special_result = op_is_rem(w_op) ? a : '1;
        end else begin
            w_special_result = op_is_rem(w_op) ? '0 : a;
        end
        w_accept   = (r_state == S_IDLE) && start;
        w_last     = (r_state == S_CALC) && (r_count == LAST_STEP);
    end

    divu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_accept),
        .i_step      (r_state == S_CALC),
        .i_dividend  (w_a_mag),
        .i_divisor   (w_b_mag),
        .o_quot_next (w_core_quot),
        .o_rem_next  (w_core_rem)
    );

    // Sign fix-up is applied to the core's final step so the registered
    // result lands on the same edge as the last iteration.
    always_comb begin
        if (r_is_rem) begin
            w_final = r_neg_r ? -w_core_rem : w_core_rem;
        end else begin
            w_final = r_neg_q ? -w_core_quot : w_core_quot;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        case (r_state)
            S_IDLE: if (start) w_next_state = w_special ? S_DONE : S_CALC;
            S_CALC: if (r_count == LAST_STEP) w_next_state = S_DONE;
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Step counter plus the sign/op context captured at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
        end else if (w_accept) begin
            r_count  <= '0;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_is_rem <= op_is_rem(w_op);
        end else if (r_state == S_CALC) begin
            r_count  <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if (w_accept && w_special) begin
            r_result <= w_special_result;
        end else if (w_last) begin
            r_result <= w_final;
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the divider: directed corner cases plus random
// operations, scored against a plain-arithmetic reference model.
module tb_divider;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] result;
        int           issueCycle;
        int           latency;
    } expect_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int      cycle   = 0;
    int      nChecks = 0;
    int      nPass   = 0;
    expect_t sbQueue[$];

    divider #(
        .WIDTH(W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // 10 ns clock and a free-running cycle index used for latency checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference model using native signed/unsigned division semantics.
    function automatic logic [W-1:0] refModel(input logic [1:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        logic            isRem;
        logic            isSigned;
        isRem    = (o == 2'b10) || (o == 2'b11);
        isSigned = (o == 2'b00) || (o == 2'b10);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        if (y == 0) return isRem ? x : {W{1'b1}};
        if (isSigned && sx == -(64'sd1 <<< (W - 1)) && sy == -1) return isRem ? '0 : x;
        if (isSigned) return isRem ? W'(sx % sy) : W'(sx / sy);
        return isRem ? W'(ux % uy) : W'(ux / uy);
    endfunction

    function automatic int refLatency(input logic [1:0] o, input logic [W-1:0] x,
                                      input logic [W-1:0] y);
        logic isSigned;
        isSigned = (o == 2'b00) || (o == 2'b10);
        if (y == 0) return 1;
        if (isSigned && x == {1'b1, {(W-1){1'b0}}} && y == {W{1'b1}}) return 1;
        return W + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse.
    always @(posedge clk) begin
        expect_t e;
        #1;
        if (done === 1'b1) begin
            if (sbQueue.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL spurious_done: done=1 with nothing pending, expected done=0 (t=%0t)", $time);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("result", result, e.result);
                checkOutput("latency", W'(cycle - e.issueCycle), W'(e.latency));
            end
        end
    end

    task automatic syncDrive();
        @(posedge clk);
        #2;
    endtask

    // Caller must be at posedge+2; start is sampled on the next edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        expect_t e;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        e.result     = refModel(o, x, y);
        e.latency    = refLatency(o, x, y);
        e.issueCycle = cycle;
        sbQueue.push_back(e);
        @(posedge clk);
        #2;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sbQueue.size() != 0 && n < budget) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (sbQueue.size() != 0) begin
            nChecks++;
            $display("[TB] FAIL timeout: %0d results still pending, expected 0", sbQueue.size());
            sbQueue.delete();
        end
    endtask

    task automatic runOp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        syncDrive();
        applyStimulus(o, x, y);
        waitDrain(W + 20);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           mode;

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #23;
        checkOutput("reset_busy", W'(busy), '0);
        checkOutput("reset_done", W'(done), '0);
        checkOutput("reset_result", result, '0);
        syncDrive();
        rst_n = 1'b1;

        // Directed corner cases.
        runOp(2'b01, 32'd100, 32'd7);
        runOp(2'b11, 32'd100, 32'd7);
        runOp(2'b00, 32'hFFFFFFF9, 32'd2);
        runOp(2'b10, 32'hFFFFFFF9, 32'd2);
        runOp(2'b01, 32'd5, 32'd0);
        runOp(2'b11, 32'd5, 32'd0);
        runOp(2'b00, 32'hFFFFFFF9, 32'd0);
        runOp(2'b10, 32'hFFFFFFF9, 32'd0);
        runOp(2'b00, 32'h80000000, 32'hFFFFFFFF);
        runOp(2'b10, 32'h80000000, 32'hFFFFFFFF);
        runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runOp(2'b01, 32'h00009129, 32'h00009111);
        runOp(2'b11, 32'h00009129, 32'h00009111);
        runOp(2'b10, 32'd7, 32'hFFFFFFFE);

        // A stray start pulse mid-CALC must be ignored.
        syncDrive();
        applyStimulus(2'b00, 32'hFFFF0000, 32'd3);
        repeat (5) @(posedge clk);
        #2;
        start = 1'b1;
        a     = 32'd1;
        b     = 32'd1;
        @(posedge clk);
        #2;
        start = 1'b0;
        waitDrain(W + 20);

        // Start held high through CALC and DONE yields exactly one result.
        syncDrive();
        op    = 2'b01;
        a     = 32'd1000;
        b     = 32'd10;
        start = 1'b1;
        begin
            expect_t e;
            e.result     = refModel(2'b01, 32'd1000, 32'd10);
            e.latency    = W + 1;
            e.issueCycle = cycle;
            sbQueue.push_back(e);
        end
        waitDrain(W + 20);
        syncDrive();
        start = 1'b0;
        checkOutput("held_start_idle", W'(busy), '0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("held_start_no_requeue", W'(busy), '0);

        // Reset in the middle of CALC aborts without a done pulse.
        syncDrive();
        applyStimulus(2'b01, 32'hDEADBEEF, 32'd13);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", W'(busy), '0);
        checkOutput("abort_done", W'(done), '0);
        checkOutput("abort_result", result, '0);
        sbQueue.delete();
        syncDrive();
        rst_n = 1'b1;
        applyStimulus(2'b01, 32'd9, 32'd3);
        waitDrain(W + 20);

        // Random operations, biased toward the special cases.
        for (int i = 0; i < 40; i++) begin
            ro   = 2'($urandom_range(0, 3));
            ra   = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                rb = '0;
            end else if (mode == 1) begin
                ra = 32'h80000000;
                rb = 32'hFFFFFFFF;
            end else if (mode == 2) begin
                rb = W'($urandom_range(1, 15));
            end else if (mode == 3) begin
                rb = -W'($urandom_range(1, 15));
            end else begin
                rb = $urandom;
            end
            runOp(ro, ra, rb);
        end

        repeat (4) @(posedge clk);
        #4;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
